// File: rtl/vga_gen.sv
// vga_gen: fixed 640x480 @ 60 Hz VGA timing and test-pattern generator.
// Pixel clock 25 MHz; colour bars on rows 0..359, 16-step grey ramp on rows
// 360..479. All outputs are registered (one clock behind the counters).
// Optional feature macro: VGA_BORDER_EN draws a 1-pixel white frame around
// the visible area.
module vga_gen (
  input  logic clk,
  input  logic rst,
  output logic r0,
  output logic r1,
  output logic r2,
  output logic r3,
  output logic g0,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic b0,
  output logic b1,
  output logic b2,
  output logic b3,
  output logic hs,
  output logic vs
);

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] H_MAX    = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  localparam logic [9:0] V_MAX    = 10'd524;
  localparam logic [9:0] V_RAMP   = 10'd360;

  logic [9:0]  count_h;
  logic [9:0]  count_v;
  logic        blank_h;
  logic        blank_v;
  logic [2:0]  bar;
  logic [3:0]  level;
  logic [11:0] pix;
  logic        hs_d;
  logic        vs_d;
  logic [11:0] rgb_q;
  logic        hs_q;
  logic        vs_q;

  // Horizontal pixel counter, 0..799 free-running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_h <= '0;
    end else if (count_h == H_MAX) begin
      count_h <= '0;
    end else begin
      count_h <= count_h + 10'd1;
    end
  end

  // Vertical line counter, advances on each line wrap, 0..524
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_v <= '0;
    end else if (count_h == H_MAX) begin
      if (count_v == V_MAX) begin
        count_v <= '0;
      end else begin
        count_v <= count_v + 10'd1;
      end
    end
  end

  assign blank_h = (count_h >= H_VIS);
  assign blank_v = (count_v >= V_VIS);
  assign hs_d    = !((count_h >= H_SYNC_S) && (count_h <= H_SYNC_E));
  assign vs_d    = !((count_v >= V_SYNC_S) && (count_v <= V_SYNC_E));

  // Bar index = count_h / 80, formed by counting crossed 80-pixel boundaries
  always_comb begin
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (count_h >= 10'(k * 80)) begin
        bar = bar + 3'd1;
      end
    end
  end

  // Grey level = count_h / 40, formed by counting crossed 40-pixel boundaries
  always_comb begin
    level = '0;
    for (int unsigned k = 1; k < 16; k++) begin
      if (count_h >= 10'(k * 40)) begin
        level = level + 4'd1;
      end
    end
  end

  // Pixel colour for the current beam position (black while blanked)
  always_comb begin
    pix = '0;
    if (!blank_h && !blank_v) begin
      if (count_v < V_RAMP) begin
        case (bar)
          3'd0:    pix = 12'hFFF;
          3'd1:    pix = 12'hFF0;
          3'd2:    pix = 12'h0FF;
          3'd3:    pix = 12'h0F0;
          3'd4:    pix = 12'hF0F;
          3'd5:    pix = 12'hF00;
          3'd6:    pix = 12'h00F;
          default: pix = 12'h000;
        endcase
      end else begin
        pix = {level, level, level};
      end
`ifdef VGA_BORDER_EN
      if ((count_h == 10'd0) || (count_h == H_VIS - 10'd1) ||
          (count_v == 10'd0) || (count_v == V_VIS - 10'd1)) begin
        pix = 12'hFFF;
      end
`endif
    end
  end

  // Output registers: colour and sync share the same one-clock latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= pix;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign {r3, r2, r1, r0} = rgb_q[11:8];
  assign {g3, g2, g1, g0} = rgb_q[7:4];
  assign {b3, b2, b1, b0} = rgb_q[3:0];
  assign hs = hs_q;
  assign vs = vs_q;

endmodule

// File: tb/tb_vga_gen.sv
// tb_vga_gen: directed self-checking bench for vga_gen. Beam positions deep
// in the frame are reached by briefly overriding the counters.
module tb_vga_gen;

`ifdef VGA_BORDER_EN
  localparam bit BRD = 1'b1;
`else
  localparam bit BRD = 1'b0;
`endif

  logic clk;
  logic rst;
  logic r0, r1, r2, r3, g0, g1, g2, g3, b0, b1, b2, b3;
  logic hs, vs;
  logic [11:0] rgb;
  logic [9:0] jh, jv;

  int vectors;
  int miscompares;

  vga_gen dut (
    .clk(clk), .rst(rst),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .g0(g0), .g1(g1), .g2(g2), .g3(g3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .hs(hs), .vs(vs)
  );

  assign rgb = {r3, r2, r1, r0, g3, g2, g1, g0, b3, b2, b1, b0};

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // Place the counters at (h,v) during the low clock phase
  task automatic jump(input logic [9:0] h, input logic [9:0] v);
    @(negedge clk);
    jh = h;
    jv = v;
    force dut.count_h = jh;
    force dut.count_v = jv;
    #1;
    release dut.count_h;
    release dut.count_v;
  endtask

  // Jump to (h,v) and clock once so the outputs show that position
  task automatic show(input logic [9:0] h, input logic [9:0] v);
    jump(h, v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (hs !== 1'b1) begin miscompares++; $display("FAIL reset_hs: got %b expected 1", hs); end
    vectors++;
    if (vs !== 1'b1) begin miscompares++; $display("FAIL reset_vs: got %b expected 1", vs); end
    vectors++;
    if (rgb !== 12'h000) begin miscompares++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
    vectors++;
    if (dut.count_h !== 10'd0 || dut.count_v !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got h=%0d v=%0d expected 0 0", dut.count_h, dut.count_v);
    end
    vectors++;
    if (dut.blank_h !== 1'b0 || dut.blank_v !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_blank: got %b%b expected 00", dut.blank_h, dut.blank_v);
    end
    rst = 1'b1;
    // sync region, then asynchronous reset between clock edges
    show(10'd656, 10'd491);
    vectors++;
    if (hs !== 1'b0 || vs !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_async_sync: got hs=%b vs=%b expected 0 0", hs, vs);
    end
    #5 rst = 1'b0;
    #1;
    vectors++;
    if (hs !== 1'b1 || vs !== 1'b1) begin
      miscompares++;
      $display("FAIL async_sync: got hs=%b vs=%b expected 1 1", hs, vs);
    end
    vectors++;
    if (dut.count_h !== 10'd0 || dut.count_v !== 10'd0) begin
      miscompares++;
      $display("FAIL async_counts: got h=%0d v=%0d expected 0 0", dut.count_h, dut.count_v);
    end
    @(negedge clk);
    rst = 1'b1;
    show(10'd100, 10'd10);
    vectors++;
    if (rgb !== 12'hFF0) begin miscompares++; $display("FAIL pre_async_rgb: got %h expected FF0", rgb); end
    #5 rst = 1'b0;
    #1;
    vectors++;
    if (rgb !== 12'h000) begin miscompares++; $display("FAIL async_rgb: got %h expected 000", rgb); end
  endtask

  task automatic test_htiming;
    int fall1, fall2, rise1, blank_cnt, seq_err;
    logic prev_hs;
    fall1 = 0; fall2 = 0; rise1 = 0; blank_cnt = 0; seq_err = 0;
    prev_hs = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 1700; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (dut.count_h !== 10'(n % 800)) seq_err++;
      if (n <= 800 && dut.blank_h === 1'b1) blank_cnt++;
      if (prev_hs === 1'b1 && hs === 1'b0) begin
        if (fall1 == 0) fall1 = n;
        else if (fall2 == 0) fall2 = n;
      end
      if (prev_hs === 1'b0 && hs === 1'b1 && rise1 == 0) rise1 = n;
      prev_hs = hs;
    end
    vectors++;
    if (fall1 != 657) begin miscompares++; $display("FAIL hs_first_fall: got %0d expected 657", fall1); end
    vectors++;
    if (rise1 - fall1 != 96) begin miscompares++; $display("FAIL hs_width: got %0d expected 96", rise1 - fall1); end
    vectors++;
    if (fall2 - fall1 != 800) begin miscompares++; $display("FAIL line_period: got %0d expected 800", fall2 - fall1); end
    vectors++;
    if (blank_cnt != 160) begin miscompares++; $display("FAIL blank_h_count: got %0d expected 160", blank_cnt); end
    vectors++;
    if (seq_err != 0) begin miscompares++; $display("FAIL count_h_seq: got %0d errors expected 0", seq_err); end
    vectors++;
    if (dut.count_v !== 10'd2) begin miscompares++; $display("FAIL count_v_lines: got %0d expected 2", dut.count_v); end
  endtask

  task automatic test_vtiming;
    int low_cnt, first_low;
    low_cnt = 0; first_low = 0;
    jump(10'd0, 10'd489);
    vectors++;
    if (dut.blank_v !== 1'b1) begin miscompares++; $display("FAIL blank_v_489: got %b expected 1", dut.blank_v); end
    for (int n = 1; n <= 4000; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (vs === 1'b0) begin
        low_cnt++;
        if (first_low == 0) first_low = n;
      end
    end
    vectors++;
    if (low_cnt != 1600) begin miscompares++; $display("FAIL vs_width: got %0d expected 1600", low_cnt); end
    vectors++;
    if (first_low != 801) begin miscompares++; $display("FAIL vs_first_low: got %0d expected 801", first_low); end
    vectors++;
    if (dut.count_v !== 10'd494) begin miscompares++; $display("FAIL count_v_after: got %0d expected 494", dut.count_v); end
    show(10'd799, 10'd524);
    vectors++;
    if (dut.count_h !== 10'd0 || dut.count_v !== 10'd0) begin
      miscompares++;
      $display("FAIL frame_wrap: got h=%0d v=%0d expected 0 0", dut.count_h, dut.count_v);
    end
    show(10'd799, 10'd479);
    vectors++;
    if (dut.count_v !== 10'd480 || dut.blank_v !== 1'b1) begin
      miscompares++;
      $display("FAIL blank_v_480: got v=%0d blank=%b expected 480 1", dut.count_v, dut.blank_v);
    end
    show(10'd798, 10'd479);
    vectors++;
    if (dut.count_v !== 10'd479 || dut.blank_v !== 1'b0) begin
      miscompares++;
      $display("FAIL blank_v_479: got v=%0d blank=%b expected 479 0", dut.count_v, dut.blank_v);
    end
  endtask

  task automatic test_bars;
    logic [9:0]  th [15] = '{10'd0, 10'd79, 10'd80, 10'd159, 10'd160, 10'd300, 10'd399,
                             10'd400, 10'd480, 10'd560, 10'd639, 10'd640, 10'd799,
                             10'd0, 10'd200};
    logic [9:0]  tv [15] = '{10'd10, 10'd10, 10'd10, 10'd10, 10'd10, 10'd10, 10'd10,
                             10'd10, 10'd10, 10'd10, 10'd10, 10'd10, 10'd10,
                             10'd359, 10'd359};
    logic [11:0] te [15] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F,
                             12'hF00, 12'h00F, 12'h000, (BRD ? 12'hFFF : 12'h000), 12'h000,
                             12'h000, 12'hFFF, 12'h0FF};
    for (int i = 0; i < 15; i++) begin
      show(th[i], tv[i]);
      vectors++;
      if (rgb !== te[i]) begin
        miscompares++;
        $display("FAIL bars[%0d] h=%0d v=%0d: got %h expected %h", i, th[i], tv[i], rgb, te[i]);
      end
    end
  endtask

  task automatic test_ramp;
    logic [9:0]  th [11] = '{10'd0, 10'd39, 10'd40, 10'd80, 10'd599, 10'd600, 10'd639,
                             10'd640, 10'd100, 10'd300, 10'd0};
    logic [9:0]  tv [11] = '{10'd400, 10'd400, 10'd400, 10'd400, 10'd400, 10'd400, 10'd400,
                             10'd400, 10'd480, 10'd524, 10'd360};
    logic [11:0] te [11] = '{(BRD ? 12'hFFF : 12'h000), 12'h000, 12'h111, 12'h222, 12'hEEE,
                             12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000,
                             (BRD ? 12'hFFF : 12'h000)};
    for (int i = 0; i < 11; i++) begin
      show(th[i], tv[i]);
      vectors++;
      if (rgb !== te[i]) begin
        miscompares++;
        $display("FAIL ramp[%0d] h=%0d v=%0d: got %h expected %h", i, th[i], tv[i], rgb, te[i]);
      end
    end
  endtask

  task automatic test_border;
    logic [9:0]  th [8] = '{10'd300, 10'd0, 10'd639, 10'd100, 10'd1, 10'd300, 10'd640, 10'd100};
    logic [9:0]  tv [8] = '{10'd0, 10'd200, 10'd200, 10'd479, 10'd1, 10'd1, 10'd0, 10'd480};
    logic [11:0] te [8] = '{(BRD ? 12'hFFF : 12'h0F0), 12'hFFF, (BRD ? 12'hFFF : 12'h000),
                            (BRD ? 12'hFFF : 12'h222), 12'hFFF, 12'h0F0, 12'h000, 12'h000};
    for (int i = 0; i < 8; i++) begin
      show(th[i], tv[i]);
      vectors++;
      if (rgb !== te[i]) begin
        miscompares++;
        $display("FAIL border[%0d] h=%0d v=%0d: got %h expected %h", i, th[i], tv[i], rgb, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] ce [4] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hFF0};
    logic        he [3] = '{1'b1, 1'b1, 1'b0};
    jump(10'd78, 10'd10);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (rgb !== ce[i]) begin
        miscompares++;
        $display("FAIL stream_rgb[%0d]: got %h expected %h", i, rgb, ce[i]);
      end
    end
    jump(10'd654, 10'd10);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (hs !== he[i] || rgb !== 12'h000) begin
        miscompares++;
        $display("FAIL stream_hs[%0d]: got hs=%b rgb=%h expected hs=%b rgb=000", i, hs, rgb, he[i]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    jh = '0;
    jv = '0;
    test_reset;
    test_htiming;
    test_vtiming;
    test_bars;
    test_ramp;
    test_border;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
